// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates fetch and data accesses onto a single-ported RAM, with data taking priority.
// Optional one-entry fetch buffer is enabled by defining PIPELINE_MEM_ARBITER_IBUF_EN.
module pipeline_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        memerr
);

    localparam logic [31:0] BADWORD = 32'hBAD0BAD0;

    typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  cnt_sat;
    logic        timed_out;

    assign cnt_sat   = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    // This cycle is the TIMEOUT-th one without ramready
    assign timed_out = ({24'd0, cnt_sat} >= TIMEOUT);

`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
    logic        ibuf_valid;
    logic [31:0] ibuf_tag;
    logic [31:0] ibuf_data;
    logic        ibuf_hit;

    assign ibuf_hit = ibuf_valid && (ibuf_tag == iaddr);
`endif

    // RAM requests follow the requester's inputs live during the access states
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state)
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            iload    <= 32'd0;
            dload    <= 32'd0;
            memerr   <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
            ibuf_valid <= 1'b0;
            ibuf_tag   <= 32'd0;
            ibuf_data  <= 32'd0;
`endif
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (dREN || dWEN) begin
                        state <= DACC;
                    end else if (iREN) begin
`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
                        if (ibuf_hit) begin
                            iload <= ibuf_data;
                            ihit  <= 1'b1;
                            state <= IRESP;
                        end else begin
                            state <= IACC;
                        end
`else
                        state <= IACC;
`endif
                    end
                end
                DACC: begin
`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
                    if (dWEN && (daddr == ibuf_tag)) ibuf_valid <= 1'b0;
`endif
                    if (ramready) begin
                        dload <= ramload;
                        dhit  <= 1'b1;
                        state <= DRESP;
                    end else if (timed_out) begin
                        dload  <= BADWORD;
                        memerr <= 1'b1;
                        dhit   <= 1'b1;
                        state  <= DRESP;
                    end else begin
                        wait_cnt <= cnt_sat;
                    end
                end
                IACC: begin
                    if (ramready) begin
                        iload <= ramload;
                        ihit  <= 1'b1;
                        state <= IRESP;
`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
                        ibuf_valid <= 1'b1;
                        ibuf_tag   <= iaddr;
                        ibuf_data  <= ramload;
`endif
                    end else if (timed_out) begin
                        iload  <= BADWORD;
                        memerr <= 1'b1;
                        ihit   <= 1'b1;
                        state  <= IRESP;
                    end else begin
                        wait_cnt <= cnt_sat;
                    end
                end
                DRESP, IRESP: state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

endmodule
